dbguart_host: RTL and testbench

- Initiator end of the debug-UART link: turns a parallel bus request into the debug-UART byte frame, pushes it into a UART core, and parses the responder's reply bytes back into a bus response.
- Sits on the host/tester side, between a local master (CPU, JTAG bridge, test sequencer) and a UART core with byte-level tx/rx handshakes.
- Handles one outstanding transaction, with a reply timeout.

---
 rtl/dbguart_host.sv | 189 ++++++++++++++++++
 tb/tb_dbguart_host.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbguart_host.sv
// Debug-UART host: serialises a bus request into a header/address/data frame,
// pushes it through a byte-level UART core and parses the ACK/NAK reply.
module dbguart_host #(
  parameter int unsigned AWID  = 32,
  parameter int unsigned TOUT  = 100000,
  parameter int unsigned TOWID = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AWID-1:0] cmd_addr,
  input  logic [31:0]     cmd_wdata,
  output logic            rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  output logic [7:0]      txdata,
  output logic            write_tx,
  input  logic            tx_empty,
  input  logic [7:0]      rxdata,
  input  logic            rx_valid,
  output logic            read_rx,
  output logic            busy
);

  localparam int unsigned ABYTES = AWID / 8;
  localparam int unsigned NB     = 1 + ABYTES + 4;
  localparam int unsigned IW     = $clog2(NB);
  localparam logic [7:0]  HDR_WR = 8'hA5;
  localparam logic [7:0]  HDR_RD = 8'h5A;
  localparam logic [7:0]  ACK    = 8'h06;

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t            state, state_d;
  logic              wr_q, wr_d;
  logic [AWID-1:0]   addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [IW-1:0]     idx, idx_d;
  logic [2:0]        rx_cnt, rx_cnt_d;
  logic [TOWID-1:0]  tcnt, tcnt_d;
  logic [31:0]       acc, acc_d;
  logic [7:0]        txdata_d;
  logic              write_tx_d, rsp_valid_d, rsp_err_d, cmd_ready_d, busy_d;
  logic [31:0]       rsp_rdata_d;
  logic [NB*8-1:0]   frame, frame_sh;
  logic [7:0]        cur_byte;
  logic [IW-1:0]     last_idx;

  // Current outgoing byte: the frame is held MSB-first, shifted by the byte index.
  always_comb begin
    frame    = {(wr_q ? HDR_WR : HDR_RD), addr_q, wdata_q};
    frame_sh = frame << {idx, 3'b000};
    cur_byte = frame_sh[NB*8-1 -: 8];
    last_idx = wr_q ? IW'(NB - 1) : IW'(ABYTES);
  end

  // rx pop is combinational so the byte is consumed on the edge that captures it.
  assign read_rx = rx_valid & ~rst & ((state == IDLE) | (state == RECV));

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      idx       <= '0;
      rx_cnt    <= '0;
      tcnt      <= '0;
      acc       <= '0;
      txdata    <= '0;
      write_tx  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      idx       <= idx_d;
      rx_cnt    <= rx_cnt_d;
      tcnt      <= tcnt_d;
      acc       <= acc_d;
      txdata    <= txdata_d;
      write_tx  <= write_tx_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      cmd_ready <= cmd_ready_d;
      busy      <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    idx_d       = idx;
    rx_cnt_d    = rx_cnt;
    tcnt_d      = tcnt;
    acc_d       = acc;
    txdata_d    = txdata;
    write_tx_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          wr_d    = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          idx_d   = '0;
          acc_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        // tx_empty may lag the push by a cycle, so skip the cycle after write_tx.
        if (tx_empty && !write_tx) begin
          txdata_d   = cur_byte;
          write_tx_d = 1'b1;
          if (idx == last_idx) begin
            tcnt_d   = '0;
            rx_cnt_d = '0;
            state_d  = RECV;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
      end

      RECV: begin
        if (rx_valid) begin
          tcnt_d = '0;
          if (rx_cnt == 3'd0) begin
            if (rxdata != ACK) begin
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_rdata_d = '0;
              state_d     = DONE;
            end else if (wr_q) begin
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b0;
              rsp_rdata_d = '0;
              state_d     = DONE;
            end else begin
              rx_cnt_d = 3'd1;
            end
          end else begin
            acc_d = {acc[23:0], rxdata};
            if (rx_cnt == 3'd4) begin
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b0;
              rsp_rdata_d = {acc[23:0], rxdata};
              state_d     = DONE;
            end else begin
              rx_cnt_d = rx_cnt + 3'd1;
            end
          end
        end else if (tcnt == TOWID'(TOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = DONE;
        end else if (tcnt != '1) begin
          tcnt_d = tcnt + TOWID'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

endmodule

// File: tb/tb_dbguart_host.sv
// Directed bench for dbguart_host: frames, ACK/NAK replies, timeout, backpressure, reset.
module tb_dbguart_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  txdata, rxdata;
  logic        write_tx, tx_empty, rx_valid, read_rx, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] txq[$];
  int  tx_last_cyc = -1;
  int  pop_cyc = 0;
  int  rsp_n = 0;
  int  rsp_cyc = 0;
  logic        rsp_e, rsp_rdy;
  logic [31:0] rsp_d;
  bit  rand_tx = 1'b0;

  dbguart_host #(.AWID(32), .TOUT(50), .TOWID(17)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .txdata(txdata), .write_tx(write_tx), .tx_empty(tx_empty),
    .rxdata(rxdata), .rx_valid(rx_valid), .read_rx(read_rx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART tx flag model: always ready, or pseudo-random when rand_tx is set.
  always @(posedge clk) begin
    #1;
    tx_empty = rand_tx ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Observe the UART-side and response traffic mid-cycle.
  always @(negedge clk) begin
    if (write_tx) begin
      if (tx_last_cyc >= 0) check_eq("wtx_gap_ge2", 32'(cyc - tx_last_cyc >= 2), 32'd1);
      txq.push_back(txdata);
      tx_last_cyc = cyc;
    end
    if (read_rx) pop_cyc = cyc;
    if (rsp_valid) begin
      rsp_n++;
      rsp_cyc = cyc;
      rsp_e   = rsp_err;
      rsp_d   = rsp_rdata;
      rsp_rdy = cmd_ready;
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!cmd_ready) check_eq("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (txq.size() < n && k < 300) begin @(posedge clk); k++; end
    #1;
    if (txq.size() < n) check_eq("tx_frame_timeout", 32'(txq.size()), 32'(n));
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp [9], input int n);
    logic [7:0] g;
    wait_tx(n);
    for (int i = 0; i < n; i++) begin
      g = (i < txq.size()) ? txq[i] : 8'hxx;
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(g), 32'(exp[i]));
    end
    check_eq({tag, "_len"}, 32'(txq.size()), 32'(n));
    txq.delete();
  endtask

  task automatic send_rx(input logic [7:0] b);
    int n = 0;
    rxdata = b; rx_valid = 1'b1;
    @(negedge clk);
    while (!read_rx && n < 300) begin @(negedge clk); n++; end
    if (!read_rx) check_eq("rx_pop_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int prev);
    int k = 0;
    while (rsp_n == prev && k < 300) begin @(posedge clk); k++; end
    #1;
    if (rsp_n == prev) check_eq("rsp_timeout", 32'd0, 32'd1);
  endtask

  int prev, ab_cyc;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rxdata = '0; rx_valid = 1'b0; tx_empty = 1'b1;
    #1;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_write_tx", 32'(write_tx), 32'd0);
    check_eq("rst_txdata", 32'(txdata), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_read_rx", 32'(read_rx), 32'd0);
    #22 rst = 1'b0;
    @(posedge clk); #1;

    // Write with ACK: 9-byte frame, error-free empty response.
    prev = rsp_n;
    issue(1'b1, 32'h1234_5678, 32'hDEAD_BEEF);
    check_frame("wr", '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 9);
    send_rx(8'h06);
    wait_rsp(prev);
    check_eq("wr_rsp_err", 32'(rsp_e), 32'd0);
    check_eq("wr_rsp_rdata", rsp_d, 32'd0);
    check_eq("wr_rsp_lat", 32'(rsp_cyc - pop_cyc), 32'd1);
    repeat (3) @(posedge clk); #1;
    check_eq("wr_rsp_single", 32'(rsp_n - prev), 32'd1);

    // Read with NAK: error, no pop while finishing, stray byte drained in IDLE.
    prev = rsp_n;
    issue(1'b0, 32'h0000_0020, 32'h0);
    check_frame("nak", '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h20, 8'h0, 8'h0, 8'h0, 8'h0}, 5);
    rxdata = 8'h15; rx_valid = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 300 && !read_rx; n++) @(negedge clk);
    @(posedge clk); #1;
    rxdata = 8'h99;
    @(negedge clk); #1;
    check_eq("nak_no_pop_done", 32'(read_rx), 32'd0);
    check_eq("nak_rsp_seen", 32'(rsp_n - prev), 32'd1);
    check_eq("nak_rsp_err", 32'(rsp_e), 32'd1);
    check_eq("nak_rsp_rdata", rsp_d, 32'd0);
    check_eq("nak_rsp_lat", 32'(rsp_cyc - pop_cyc), 32'd1);
    @(posedge clk); #1;
    check_eq("idle_drain", 32'(read_rx), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;

    // Read with ACK and four data bytes.
    prev = rsp_n;
    issue(1'b0, 32'h0000_0040, 32'h0);
    check_frame("rd", '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h40, 8'h0, 8'h0, 8'h0, 8'h0}, 5);
    send_rx(8'h06); send_rx(8'hCA); send_rx(8'hFE); send_rx(8'hF0); send_rx(8'h0D);
    wait_rsp(prev);
    check_eq("rd_rsp_err", 32'(rsp_e), 32'd0);
    check_eq("rd_rsp_rdata", rsp_d, 32'hCAFE_F00D);
    check_eq("rd_rsp_lat", 32'(rsp_cyc - pop_cyc), 32'd1);
    check_eq("rd_rdata_hold", rsp_rdata, 32'hCAFE_F00D);

    // Partial reply then silence: timeout 50 cycles after the last capture edge.
    prev = rsp_n;
    issue(1'b0, 32'h0000_0010, 32'h0);
    check_frame("to", '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h10, 8'h0, 8'h0, 8'h0, 8'h0}, 5);
    send_rx(8'h06); send_rx(8'hAB);
    ab_cyc = pop_cyc;
    wait_rsp(prev);
    check_eq("to_rsp_err", 32'(rsp_e), 32'd1);
    check_eq("to_rsp_rdata", rsp_d, 32'd0);
    check_eq("to_delay", 32'(rsp_cyc - (ab_cyc + 1)), 32'd50);

    // Random tx backpressure with a second request held through the first.
    rand_tx = 1'b1;
    prev = rsp_n;
    cmd_write = 1'b0; cmd_addr = 32'h0000_0080; cmd_wdata = '0; cmd_valid = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 300 && !cmd_ready; n++) @(negedge clk);
    @(posedge clk); #1;
    cmd_write = 1'b1; cmd_addr = 32'hAABB_CCDD; cmd_wdata = 32'h1122_3344;
    check_eq("bp_ready_low", 32'(cmd_ready), 32'd0);
    check_frame("bp1", '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h80, 8'h0, 8'h0, 8'h0, 8'h0}, 5);
    send_rx(8'h06); send_rx(8'h01); send_rx(8'h02); send_rx(8'h03); send_rx(8'h04);
    wait_rsp(prev);
    check_eq("bp1_rsp_rdata", rsp_d, 32'h0102_0304);
    check_eq("bp1_rsp_err", 32'(rsp_e), 32'd0);
    check_eq("bp1_rdy_at_rsp", 32'(rsp_rdy), 32'd0);
    check_eq("bp1_rdy_after", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_eq("bp2_accepted", 32'(busy), 32'd1);
    prev = rsp_n;
    check_frame("bp2", '{8'hA5, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44}, 9);
    send_rx(8'h06);
    wait_rsp(prev);
    check_eq("bp2_rsp_err", 32'(rsp_e), 32'd0);
    check_eq("bp2_rsp_rdata", rsp_d, 32'd0);
    rand_tx = 1'b0;

    // Reset mid-frame after the third byte, then a clean full frame.
    prev = rsp_n;
    issue(1'b1, 32'h0102_0304, 32'h0506_0708);
    wait_tx(3);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_write_tx", 32'(write_tx), 32'd0);
    check_eq("mid_rst_txdata", 32'(txdata), 32'd0);
    check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    txq.delete();
    tx_last_cyc = -1;
    @(posedge clk); #1;
    check_eq("mid_rst_no_rsp", 32'(rsp_n - prev), 32'd0);
    issue(1'b0, 32'h4433_2211, 32'h0);
    check_frame("post_rst", '{8'h5A, 8'h44, 8'h33, 8'h22, 8'h11, 8'h0, 8'h0, 8'h0, 8'h0}, 5);
    send_rx(8'h06); send_rx(8'h00); send_rx(8'h00); send_rx(8'h00); send_rx(8'h07);
    wait_rsp(prev);
    check_eq("post_rst_rdata", rsp_d, 32'h0000_0007);
    check_eq("post_rst_err", 32'(rsp_e), 32'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
